interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter VEC_BASE, default 16'hFFFA, meaning address of NMI vector low byte; RESET = VEC_BASE+2, IRQ = VEC_BASE+4.
REQ-002 SHALL have port clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enableFFs  input  1  global clock enable; state advances only when high.
REQ-005 SHALL have port irqGenerated  input  1  pending maskable interrupt.
REQ-006 SHALL have port nmiGenerated  input  1  pending non-maskable interrupt.
REQ-007 SHALL have port resetDetected  input  1  reset sequence request.
REQ-008 SHALL have port instructionBoundary  input  1  high in the opcode-fetch cycle of the core.
REQ-009 SHALL have port interruptAcknowleged  output  1  one-cycle pulse when a request is accepted.
REQ-010 SHALL have port sequenceActive  output  1  high while the sequence owns the bus.
REQ-011 SHALL have port pushEn  output  1  stack write this cycle.
REQ-012 SHALL have port pushSel  output  2  pushed byte: 0 PCH, 1 PCL, 2 P.
REQ-013 SHALL have port breakFlagOut  output  1  B bit for pushed P; always 0.
REQ-014 SHALL have port vectorRead  output  1  vector fetch this cycle.
REQ-015 SHALL have port vectorAddr  output  16  vector byte address.
REQ-016 SHALL have port setIFlag  output  1  one-cycle pulse setting processor I flag.

Function
REQ-017 SHALL implement states IDLE, DUMMY1, DUMMY2, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, advancing one state per enabled cycle, VEC_HI -> IDLE.
REQ-018 SHALL accept a request in IDLE only when instructionBoundary=1 and enableFFs=1; priority resetDetected > nmiGenerated > irqGenerated.
REQ-019 SHALL latch accepted source (RESET/NMI/IRQ) into a 2-bit register and enter DUMMY1 on the accepting edge.
REQ-020 SHALL assert interruptAcknowleged combinationally in the accepting cycle only.
REQ-021 SHALL assert sequenceActive in every non-IDLE state.
REQ-022 SHALL assert pushEn in PUSH_PCH/PUSH_PCL/PUSH_P with pushSel 0/1/2, except source RESET, which performs the same states with pushEn=0.
REQ-023 SHALL assert vectorRead in VEC_LO (vectorAddr = vector base) and VEC_HI (base+1).
REQ-024 SHALL pulse setIFlag in VEC_LO for all sources.
REQ-025 SHALL, if nmiGenerated rises while source=IRQ and state before VEC_LO, change source to NMI (hijack); pushes already issued are unchanged.
REQ-026 SHALL, on resetDetected in any non-IDLE state, set source RESET and restart at DUMMY1.
REQ-027 SHALL hold state and all registers when enableFFs=0; outputs reflect held state.
REQ-028 SHALL ignore requests while non-IDLE except REQ-025/REQ-026; sequence length fixed at 7 cycles.
REQ-029 SHALL drive vectorAddr = 16'h0000 in states other than VEC_LO/VEC_HI.

Reset
REQ-030 SHALL on rst=1 asynchronously force IDLE, source IRQ, all outputs 0.
REQ-031 SHALL resume on first enabled edge after rst deassertion; no request accepted in the same cycle rst falls.

Structure
REQ-032 SHALL place state enum, source enum and default vector offsets in shared package interrupt_pkg.
REQ-033 SHALL be a single module; no sub-module is natural (vector mux and FSM inline).

Verification
REQ-034 IRQ at boundary -> ack pulse, pushes PCH/PCL/P on cycles 3-5, vectorAddr FFFE then FFFF, setIFlag in cycle 6.
REQ-035 Simultaneous reset+NMI+IRQ at boundary -> source RESET, pushEn never high, vectorAddr FFFC/FFFD.
REQ-036 NMI rises in PUSH_PCL of IRQ sequence -> vectorAddr FFFA/FFFB, 3 pushes total.
REQ-037 resetDetected in PUSH_P -> next state DUMMY1, remaining sequence 7 cycles, vector FFFC.
REQ-038 enableFFs low for 3 cycles mid-PUSH_PCH -> state/outputs frozen, total sequence 10 cycles.
REQ-039 rst asserted in VEC_LO -> immediate IDLE, all outputs 0 before next clk edge.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared types and vector layout for the interrupt/reset entry sequencer.
package interrupt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DUMMY1   = 3'd1,
        ST_DUMMY2   = 3'd2,
        ST_PUSH_PCH = 3'd3,
        ST_PUSH_PCL = 3'd4,
        ST_PUSH_P   = 3'd5,
        ST_VEC_LO   = 3'd6,
        ST_VEC_HI   = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        SRC_NMI   = 2'd0,
        SRC_RESET = 2'd1,
        SRC_IRQ   = 2'd2
    } irq_src_e;

    localparam logic [15:0] VEC_OFS_NMI   = 16'd0;
    localparam logic [15:0] VEC_OFS_RESET = 16'd2;
    localparam logic [15:0] VEC_OFS_IRQ   = 16'd4;

    localparam logic [1:0] PUSH_SEL_PCH = 2'd0;
    localparam logic [1:0] PUSH_SEL_PCL = 2'd1;
    localparam logic [1:0] PUSH_SEL_P   = 2'd2;

    function automatic logic [15:0] vec_offset(input irq_src_e src);
        case (src)
            SRC_RESET: return VEC_OFS_RESET;
            SRC_IRQ:   return VEC_OFS_IRQ;
            default:   return VEC_OFS_NMI;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// Seven-cycle interrupt/reset entry sequence: two dummy cycles, three stack
// pushes (suppressed for reset), then the two vector byte fetches.
//
// state    | meaning
// IDLE     | core running; accept a request at an instruction boundary
// DUMMY1/2 | bus-owning dead cycles
// PUSH_*   | push PCH, PCL, P (no write for reset)
// VEC_LO/HI| fetch vector bytes; I flag set in VEC_LO
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = 16'hFFFA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enableFFs,
    input  logic        irqGenerated,
    input  logic        nmiGenerated,
    input  logic        resetDetected,
    input  logic        instructionBoundary,
    output logic        interruptAcknowleged,
    output logic        sequenceActive,
    output logic        pushEn,
    output logic [1:0]  pushSel,
    output logic        breakFlagOut,
    output logic        vectorRead,
    output logic [15:0] vectorAddr,
    output logic        setIFlag
);

    seq_state_e  state_q, state_d;
    irq_src_e    src_q, src_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        accept;
    logic        nmi_rise;
    logic        pre_vector;
    logic [15:0] vec_addr_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_IRQ;
            nmi_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            nmi_prev_q <= nmi_prev_d;
        end
    end

    always_comb begin
        accept = (state_q == ST_IDLE) && instructionBoundary && enableFFs && !rst &&
                 (resetDetected || nmiGenerated || irqGenerated);
        nmi_rise   = nmiGenerated && !nmi_prev_q;
        pre_vector = (state_q == ST_DUMMY1) || (state_q == ST_DUMMY2) ||
                     (state_q == ST_PUSH_PCH) || (state_q == ST_PUSH_PCL) ||
                     (state_q == ST_PUSH_P);
        state_d    = state_q;
        src_d      = src_q;
        nmi_prev_d = nmi_prev_q;

        if (enableFFs) begin
            nmi_prev_d = nmiGenerated;
            if (state_q == ST_IDLE) begin
                if (accept) begin
                    state_d = ST_DUMMY1;
                    if (resetDetected)     src_d = SRC_RESET;
                    else if (nmiGenerated) src_d = SRC_NMI;
                    else                   src_d = SRC_IRQ;
                end
            end else if (resetDetected) begin
                state_d = ST_DUMMY1;
                src_d   = SRC_RESET;
            end else begin
                // A fresh NMI edge redirects an IRQ entry as long as the vector
                // has not started; pushes already done are identical for both.
                if (src_q == SRC_IRQ && nmi_rise && pre_vector) src_d = SRC_NMI;
                case (state_q)
                    ST_DUMMY1:   state_d = ST_DUMMY2;
                    ST_DUMMY2:   state_d = ST_PUSH_PCH;
                    ST_PUSH_PCH: state_d = ST_PUSH_PCL;
                    ST_PUSH_PCL: state_d = ST_PUSH_P;
                    ST_PUSH_P:   state_d = ST_VEC_LO;
                    ST_VEC_LO:   state_d = ST_VEC_HI;
                    default:     state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        vec_addr_base        = VEC_BASE + vec_offset(src_q);
        interruptAcknowleged = accept;
        sequenceActive       = (state_q != ST_IDLE);
        pushEn               = 1'b0;
        pushSel              = PUSH_SEL_PCH;
        breakFlagOut         = 1'b0;
        vectorRead           = 1'b0;
        vectorAddr           = 16'h0000;
        setIFlag             = 1'b0;
        case (state_q)
            ST_PUSH_PCH: begin
                pushEn  = (src_q != SRC_RESET);
                pushSel = PUSH_SEL_PCH;
            end
            ST_PUSH_PCL: begin
                pushEn  = (src_q != SRC_RESET);
                pushSel = PUSH_SEL_PCL;
            end
            ST_PUSH_P: begin
                pushEn  = (src_q != SRC_RESET);
                pushSel = PUSH_SEL_P;
            end
            ST_VEC_LO: begin
                vectorRead = 1'b1;
                vectorAddr = vec_addr_base;
                setIFlag   = 1'b1;
            end
            ST_VEC_HI: begin
                vectorRead = 1'b1;
                vectorAddr = vec_addr_base + 16'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed scoreboard bench for interrupt_sequencer: expected per-cycle output
// vectors are queued when a sequence is launched and popped each cycle.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enableFFs = 1'b0;
    logic        irqGenerated = 1'b0;
    logic        nmiGenerated = 1'b0;
    logic        resetDetected = 1'b0;
    logic        instructionBoundary = 1'b0;
    logic        interruptAcknowleged;
    logic        sequenceActive;
    logic        pushEn;
    logic [1:0]  pushSel;
    logic        breakFlagOut;
    logic        vectorRead;
    logic [15:0] vectorAddr;
    logic        setIFlag;

    typedef struct {
        string       tag;
        logic [23:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    interrupt_sequencer #(.VEC_BASE(16'hFFFA)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enableFFs           (enableFFs),
        .irqGenerated        (irqGenerated),
        .nmiGenerated        (nmiGenerated),
        .resetDetected       (resetDetected),
        .instructionBoundary (instructionBoundary),
        .interruptAcknowleged(interruptAcknowleged),
        .sequenceActive      (sequenceActive),
        .pushEn              (pushEn),
        .pushSel             (pushSel),
        .breakFlagOut        (breakFlagOut),
        .vectorRead          (vectorRead),
        .vectorAddr          (vectorAddr),
        .setIFlag            (setIFlag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    // {ack, active, pushEn, pushSel[1:0], vectorRead, vectorAddr[15:0], setIFlag, breakFlag}
    function automatic logic [23:0] pack_exp(logic ack, logic act, logic pen, logic [1:0] psel,
                                             logic vrd, logic [15:0] va, logic seti);
        return {ack, act, pen, psel, vrd, va, seti, 1'b0};
    endfunction

    // Expected outputs for sequence cycle ph (1 = DUMMY1 ... 7 = VEC_HI).
    function automatic logic [23:0] phase_exp(int ph, bit no_push, logic [15:0] vb);
        logic        pen;
        logic [1:0]  psel;
        logic        vrd;
        logic [15:0] va;
        logic        seti;
        pen  = 1'b0;
        psel = 2'd0;
        vrd  = 1'b0;
        va   = 16'h0000;
        seti = 1'b0;
        if (ph >= 3 && ph <= 5) begin
            pen  = !no_push;
            psel = 2'(ph - 3);
        end else if (ph == 6) begin
            vrd  = 1'b1;
            va   = vb;
            seti = 1'b1;
        end else if (ph == 7) begin
            vrd  = 1'b1;
            va   = vb + 16'd1;
        end
        return pack_exp(1'b0, 1'b1, pen, psel, vrd, va, seti);
    endfunction

    task automatic push_idle(input string tag, input logic ack);
        exp_t e;
        e.tag = tag;
        e.v   = pack_exp(ack, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0);
        sb.push_back(e);
    endtask

    task automatic push_seq(input string tag, input int first_ph, input int last_ph,
                            input bit no_push, input logic [15:0] vb);
        exp_t e;
        for (int ph = first_ph; ph <= last_ph; ph++) begin
            e.tag = $sformatf("%s_ph%0d", tag, ph);
            e.v   = phase_exp(ph, no_push, vb);
            sb.push_back(e);
        end
    endtask

    task automatic check();
        exp_t        e;
        logic [23:0] obs;
        obs = {interruptAcknowleged, sequenceActive, pushEn, pushSel, vectorRead,
               vectorAddr, setIFlag, breakFlagOut};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%h expected=queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step(input bit en, input bit bnd, input bit irq, input bit nmi, input bit rstd);
        @(negedge clk);
        enableFFs           = en;
        instructionBoundary = bnd;
        irqGenerated        = irq;
        nmiGenerated        = nmi;
        resetDetected       = rstd;
        #1;
        check();
    endtask

    initial begin
        // Reset held with live requests: nothing acknowledged, all outputs low.
        push_idle("in_reset", 1'b0);
        @(negedge clk);
        enableFFs = 1'b1; irqGenerated = 1'b1; instructionBoundary = 1'b1;
        #1;
        check();
        @(negedge clk);
        rst = 1'b0; irqGenerated = 1'b0; instructionBoundary = 1'b0;

        push_idle("idle_no_boundary", 1'b0);
        step(1, 0, 1, 0, 0);
        push_idle("idle_disabled", 1'b0);
        step(0, 1, 1, 0, 0);

        // IRQ entry; requests held through the sequence must be ignored.
        push_idle("irq_ack", 1'b1);
        push_seq("irq", 1, 7, 0, 16'hFFFE);
        push_idle("irq_done", 1'b0);
        step(1, 1, 1, 0, 0);
        repeat (6) step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Reset beats NMI beats IRQ; no stack writes for reset.
        push_idle("all_ack", 1'b1);
        push_seq("all_rst", 1, 7, 1, 16'hFFFC);
        push_idle("all_done", 1'b0);
        step(1, 1, 1, 1, 1);
        repeat (7) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // NMI edge during PUSH_PCL hijacks the IRQ vector.
        push_idle("hij_ack", 1'b1);
        push_seq("hij_irq", 1, 5, 0, 16'hFFFE);
        push_seq("hij_nmi", 6, 7, 0, 16'hFFFA);
        push_idle("hij_done", 1'b0);
        step(1, 1, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);

        // resetDetected in PUSH_P restarts a full reset sequence.
        push_idle("rmid_ack", 1'b1);
        push_seq("rmid_irq", 1, 5, 0, 16'hFFFE);
        push_seq("rmid_rst", 1, 7, 1, 16'hFFFC);
        push_idle("rmid_done", 1'b0);
        step(1, 1, 1, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        repeat (7) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Three disabled cycles in PUSH_PCH stretch the sequence to 10 cycles.
        push_idle("stall_ack", 1'b1);
        push_seq("stall", 1, 2, 0, 16'hFFFE);
        repeat (4) push_seq("stall_hold", 3, 3, 0, 16'hFFFE);
        push_seq("stall", 4, 7, 0, 16'hFFFE);
        push_idle("stall_done", 1'b0);
        step(1, 1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Async reset in VEC_LO clears outputs before the next edge.
        push_idle("nmi_ack", 1'b1);
        push_seq("nmi", 1, 6, 0, 16'hFFFA);
        push_idle("async_rst", 1'b0);
        step(1, 1, 0, 1, 0);
        repeat (6) step(1, 0, 0, 1, 0);
        rst = 1'b1;
        #1;
        check();
        @(negedge clk);
        rst = 1'b0;

        // Normal operation resumes after reset release.
        push_idle("post_rst_idle", 1'b0);
        push_idle("post_rst_ack", 1'b1);
        push_seq("post_rst", 1, 1, 0, 16'hFFFE);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
